// File: rtl/task_slot_pkg.sv
// Shared types and default sizing for the task slot controller.
// Contents:
//   slot_state_e   - per-slot lifecycle state (3 bits)
//   NumSlotsDefault, IdWDefault, TagWDefault - default pool geometry
//   slot_rec_t     - one slot record {state, tag} at the default tag width
package task_slot_pkg;

   localparam int unsigned NumSlotsDefault = 4;
   localparam int unsigned IdWDefault      = 2;
   localparam int unsigned TagWDefault     = 8;

   typedef enum logic [2:0] {
      SlotFree    = 3'd0,
      SlotFsttask = 3'd1,
      SlotWait    = 3'd2,
      SlotNxttask = 3'd3,
      SlotDone    = 3'd4
   } slot_state_e;

   typedef struct packed {
      slot_state_e            state;
      logic [TagWDefault-1:0] tag;
   } slot_rec_t;

endpackage

// File: rtl/task_rr_arb.sv
// Round-robin arbiter over the slot fetch requests. Purely combinational.
// Priority starts at ptr_i+1 and wraps, so the last granted slot is lowest priority.
// Ports:
//   req_i  - one request bit per slot
//   ptr_i  - index of the most recently granted slot
//   gnt_o  - one-hot grant (all zero when nothing requests)
//   id_o   - index of the granted slot (0 when nothing requests)
module task_rr_arb #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned ID_W      = 2
) (
   input  logic [NUM_SLOTS-1:0] req_i,
   input  logic [ID_W-1:0]      ptr_i,
   output logic [NUM_SLOTS-1:0] gnt_o,
   output logic [ID_W-1:0]      id_o
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      found = 1'b0;
      idx   = '0;
      // NUM_SLOTS is a power of two, so the ID_W-bit add wraps for free;
      // i == NUM_SLOTS lands back on ptr_i itself as the last candidate.
      for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
         idx = ptr_i + ID_W'(i);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            id_o       = idx;
         end
      end
   end

endmodule

// File: rtl/task_slot_ctrl.sv
// Task slot pool controller: allocates slots to the dispatcher, arbitrates the
// instruction-fetch port among slots needing a fetch, and retires finished slots.
// Optional feature macro: TASK_SLOT_PERF_EN adds three saturating 32-bit counters.
// Ports:
//   clock, reset                - clock and synchronous active-high reset
//   io_alloc_*                  - slot allocation handshake (lowest FREE slot)
//   io_fthInst_*                - fetch request (round-robin, locked while stalled)
//   io_resp_*                   - fetch responses per slot; last retires the task
//   io_release_valid/id         - one-cycle retire notification (lowest DONE slot)
//   io_busy                     - any slot not FREE
//   io_perf_* (macro only)      - alloc / fetch handshake and stall-cycle counts
module task_slot_ctrl
   import task_slot_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = NumSlotsDefault,
   parameter int unsigned ID_W      = IdWDefault,
   parameter int unsigned TAG_W     = TagWDefault
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_alloc_valid,
   input  logic [TAG_W-1:0] io_alloc_tag,
   output logic             io_alloc_ready,
   output logic [ID_W-1:0]  io_alloc_id,
   output logic             io_fthInst_valid,
   input  logic             io_fthInst_ready,
   output logic [ID_W-1:0]  io_fthInst_id,
   output logic [TAG_W-1:0] io_fthInst_tag,
   input  logic             io_resp_valid,
   input  logic [ID_W-1:0]  io_resp_id,
   input  logic             io_resp_last,
   output logic             io_release_valid,
   output logic [ID_W-1:0]  io_release_id,
`ifdef TASK_SLOT_PERF_EN
   output logic [31:0]      io_perf_allocs,
   output logic [31:0]      io_perf_fetches,
   output logic [31:0]      io_perf_stalls,
`endif
   output logic             io_busy
);

   slot_state_e            state_q [NUM_SLOTS];
   slot_state_e            state_d [NUM_SLOTS];
   logic [TAG_W-1:0]       tag_q   [NUM_SLOTS];
   logic [TAG_W-1:0]       tag_d   [NUM_SLOTS];
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic                   lock_q, lock_d;
   logic [ID_W-1:0]        lock_id_q, lock_id_d;

   logic [NUM_SLOTS-1:0]   req, arb_gnt;
   logic [ID_W-1:0]        arb_id, fth_sel;
   logic                   fth_valid, fth_hs, alloc_hs;

   always_comb begin
      req              = '0;
      io_alloc_ready   = 1'b0;
      io_alloc_id      = '0;
      io_release_valid = 1'b0;
      io_release_id    = '0;
      io_busy          = 1'b0;
      // Walk downwards so the lowest matching index is the one left standing.
      for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
         req[i] = (state_q[i] == SlotFsttask) || (state_q[i] == SlotNxttask);
         if (state_q[i] == SlotFree) begin
            io_alloc_ready = 1'b1;
            io_alloc_id    = ID_W'(i);
         end else begin
            io_busy = 1'b1;
         end
         if (state_q[i] == SlotDone) begin
            io_release_valid = 1'b1;
            io_release_id    = ID_W'(i);
         end
      end
   end

   task_rr_arb #(
      .NUM_SLOTS (NUM_SLOTS),
      .ID_W      (ID_W)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .id_o  (arb_id)
   );

   // A stalled request keeps its slot even if a higher-priority slot starts requesting.
   assign fth_valid        = lock_q | (|arb_gnt);
   assign fth_sel          = lock_q ? lock_id_q : arb_id;
   assign fth_hs           = fth_valid & io_fthInst_ready;
   assign alloc_hs         = io_alloc_valid & io_alloc_ready;
   assign io_fthInst_valid = fth_valid;
   assign io_fthInst_id    = fth_valid ? fth_sel : '0;
   assign io_fthInst_tag   = fth_valid ? tag_q[fth_sel] : '0;

   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      ptr_d     = ptr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      // The four updates below always hit slots in different states, so they never collide.
      if (alloc_hs) begin
         state_d[io_alloc_id] = SlotFsttask;
         tag_d[io_alloc_id]   = io_alloc_tag;
      end
      if (fth_hs) begin
         state_d[fth_sel] = SlotWait;
         ptr_d            = fth_sel;
         lock_d           = 1'b0;
      end else if (fth_valid) begin
         lock_d    = 1'b1;
         lock_id_d = fth_sel;
      end
      if (io_resp_valid && (state_q[io_resp_id] == SlotWait)) begin
         state_d[io_resp_id] = io_resp_last ? SlotDone : SlotNxttask;
      end
      if (io_release_valid) begin
         state_d[io_release_id] = SlotFree;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            state_q[i] <= SlotFree;
            tag_q[i]   <= '0;
         end
         ptr_q     <= ID_W'(NUM_SLOTS - 1);
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         tag_q     <= tag_d;
         ptr_q     <= ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

`ifdef TASK_SLOT_PERF_EN
   logic [31:0] allocs_q, allocs_d, fetches_q, fetches_d, stalls_q, stalls_d;

   always_comb begin
      allocs_d  = allocs_q;
      fetches_d = fetches_q;
      stalls_d  = stalls_q;
      if (alloc_hs && (allocs_q != '1)) allocs_d = allocs_q + 32'd1;
      if (fth_hs && (fetches_q != '1)) fetches_d = fetches_q + 32'd1;
      if (fth_valid && !io_fthInst_ready && (stalls_q != '1)) stalls_d = stalls_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         allocs_q  <= '0;
         fetches_q <= '0;
         stalls_q  <= '0;
      end else begin
         allocs_q  <= allocs_d;
         fetches_q <= fetches_d;
         stalls_q  <= stalls_d;
      end
   end

   assign io_perf_allocs  = allocs_q;
   assign io_perf_fetches = fetches_q;
   assign io_perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_task_slot_ctrl.sv
// Self-checking bench for task_slot_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a slot-pool model held in the bench.
module tb_task_slot_ctrl;

   localparam int N = 4;
   localparam int M_FREE = 0, M_FST = 1, M_WAIT = 2, M_NXT = 3, M_DONE = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       io_alloc_valid;
   logic [7:0] io_alloc_tag;
   logic       io_alloc_ready;
   logic [1:0] io_alloc_id;
   logic       io_fthInst_valid;
   logic       io_fthInst_ready;
   logic [1:0] io_fthInst_id;
   logic [7:0] io_fthInst_tag;
   logic       io_resp_valid;
   logic [1:0] io_resp_id;
   logic       io_resp_last;
   logic       io_release_valid;
   logic [1:0] io_release_id;
   logic       io_busy;
`ifdef TASK_SLOT_PERF_EN
   logic [31:0] io_perf_allocs, io_perf_fetches, io_perf_stalls;
`endif

   task_slot_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .io_alloc_valid   (io_alloc_valid),
      .io_alloc_tag     (io_alloc_tag),
      .io_alloc_ready   (io_alloc_ready),
      .io_alloc_id      (io_alloc_id),
      .io_fthInst_valid (io_fthInst_valid),
      .io_fthInst_ready (io_fthInst_ready),
      .io_fthInst_id    (io_fthInst_id),
      .io_fthInst_tag   (io_fthInst_tag),
      .io_resp_valid    (io_resp_valid),
      .io_resp_id       (io_resp_id),
      .io_resp_last     (io_resp_last),
      .io_release_valid (io_release_valid),
      .io_release_id    (io_release_id),
`ifdef TASK_SLOT_PERF_EN
      .io_perf_allocs   (io_perf_allocs),
      .io_perf_fetches  (io_perf_fetches),
      .io_perf_stalls   (io_perf_stalls),
`endif
      .io_busy          (io_busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Model of the pool: per-slot lifecycle, tags, last granted slot, stalled request.
   int         m_st [N];
   logic [7:0] m_tag [N];
   int         m_last;
   bit         m_lock;
   int         m_lock_id;
   int         p_allocs, p_fetches, p_stalls;

   // Expected outputs for the current model state.
   int         e_aready, e_aid, e_fv, e_fid, e_rv, e_rid, e_busy;
   logic [7:0] e_ftag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i]  = M_FREE;
         m_tag[i] = 8'h00;
      end
      m_last    = N - 1;
      m_lock    = 1'b0;
      m_lock_id = 0;
      p_allocs  = 0;
      p_fetches = 0;
      p_stalls  = 0;
   endtask

   task automatic model_outputs();
      e_aready = 0; e_aid = 0; e_rv = 0; e_rid = 0; e_busy = 0;
      e_fv = 0; e_fid = 0; e_ftag = 8'h00;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_st[i] == M_FREE) begin
            e_aready = 1;
            e_aid    = i;
         end else begin
            e_busy = 1;
         end
         if (m_st[i] == M_DONE) begin
            e_rv  = 1;
            e_rid = i;
         end
      end
      if (m_lock) begin
         e_fv  = 1;
         e_fid = m_lock_id;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (e_fv == 0 && (m_st[j] == M_FST || m_st[j] == M_NXT)) begin
               e_fv  = 1;
               e_fid = j;
            end
         end
      end
      if (e_fv != 0) e_ftag = m_tag[e_fid];
   endtask

   task automatic model_step();
      int ns [N];
      if (reset) begin
         model_reset();
         return;
      end
      ns = m_st;
      if (io_alloc_valid && e_aready != 0) begin
         ns[e_aid]    = M_FST;
         m_tag[e_aid] = io_alloc_tag;
         p_allocs++;
      end
      if (e_fv != 0 && io_fthInst_ready) begin
         ns[e_fid] = M_WAIT;
         m_last    = e_fid;
         m_lock    = 1'b0;
         p_fetches++;
      end else if (e_fv != 0) begin
         m_lock    = 1'b1;
         m_lock_id = e_fid;
         p_stalls++;
      end
      if (io_resp_valid && m_st[io_resp_id] == M_WAIT) ns[io_resp_id] = io_resp_last ? M_DONE : M_NXT;
      if (e_rv != 0) ns[e_rid] = M_FREE;
      m_st = ns;
   endtask

   // Drive one cycle of inputs, compare all outputs against the model, advance past the edge.
   task automatic cycle(input bit av, input logic [7:0] at, input bit fr, input bit rv,
                        input logic [1:0] rid, input bit rl, input bit rst);
      io_alloc_valid   = av;
      io_alloc_tag     = at;
      io_fthInst_ready = fr;
      io_resp_valid    = rv;
      io_resp_id       = rid;
      io_resp_last     = rl;
      reset            = rst;
      #3;
      model_outputs();
      chk("alloc_ready", 32'(io_alloc_ready), 32'(e_aready));
      chk("alloc_id", 32'(io_alloc_id), 32'(e_aid));
      chk("fth_valid", 32'(io_fthInst_valid), 32'(e_fv));
      chk("fth_id", 32'(io_fthInst_id), 32'(e_fid));
      chk("fth_tag", 32'(io_fthInst_tag), 32'(e_ftag));
      chk("release_valid", 32'(io_release_valid), 32'(e_rv));
      chk("release_id", 32'(io_release_id), 32'(e_rid));
      chk("busy", 32'(io_busy), 32'(e_busy));
`ifdef TASK_SLOT_PERF_EN
      chk("perf_allocs", io_perf_allocs, 32'(p_allocs));
      chk("perf_fetches", io_perf_fetches, 32'(p_fetches));
      chk("perf_stalls", io_perf_stalls, 32'(p_stalls));
`endif
      model_step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      io_alloc_valid = 1'b0; io_alloc_tag = 8'h00; io_fthInst_ready = 1'b0;
      io_resp_valid = 1'b0; io_resp_id = 2'd0; io_resp_last = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      model_reset();

      // Reset values while reset is held.
      cycle(0, 8'h00, 0, 0, 2'd0, 0, 1);
      chk("rst_alloc_ready", 32'(io_alloc_ready), 32'd1);
      chk("rst_alloc_id", 32'(io_alloc_id), 32'd0);
      chk("rst_fth_valid", 32'(io_fthInst_valid), 32'd0);
      chk("rst_release_valid", 32'(io_release_valid), 32'd0);
      chk("rst_busy", 32'(io_busy), 32'd0);

      // First alloc: slot 0, requesting a fetch one cycle later.
      chk("first_alloc_id", 32'(io_alloc_id), 32'd0);
      cycle(1, 8'h5A, 0, 0, 2'd0, 0, 0);
      chk("first_fth_valid", 32'(io_fthInst_valid), 32'd1);
      chk("first_fth_id", 32'(io_fthInst_id), 32'd0);
      chk("first_fth_tag", 32'(io_fthInst_tag), 32'h5A);

      // Fill the pool; a fifth request is held off.
      cycle(1, 8'h11, 0, 0, 2'd0, 0, 0);
      cycle(1, 8'h22, 0, 0, 2'd0, 0, 0);
      cycle(1, 8'h33, 0, 0, 2'd0, 0, 0);
      chk("full_alloc_ready", 32'(io_alloc_ready), 32'd0);
      cycle(1, 8'h44, 0, 0, 2'd0, 0, 0);
      chk("full_held", 32'(io_alloc_ready), 32'd0);

      // All four requesting: grants in order 0..3.
      for (int k = 0; k < N; k++) begin
         chk("grant_order", 32'(io_fthInst_id), 32'(k));
         cycle(0, 8'h00, 1, 0, 2'd0, 0, 0);
      end
      chk("all_wait_fth_valid", 32'(io_fthInst_valid), 32'd0);

      // Slot 2 stalls; slot 0 starts requesting but the lock holds slot 2.
      cycle(0, 8'h00, 0, 1, 2'd2, 0, 0);
      chk("lock_id_a", 32'(io_fthInst_id), 32'd2);
      cycle(0, 8'h00, 0, 0, 2'd0, 0, 0);
      chk("lock_id_b", 32'(io_fthInst_id), 32'd2);
      cycle(0, 8'h00, 0, 1, 2'd0, 0, 0);
      chk("lock_id_c", 32'(io_fthInst_id), 32'd2);
      chk("lock_tag", 32'(io_fthInst_tag), 32'h22);
      cycle(0, 8'h00, 0, 0, 2'd0, 0, 0);
      chk("lock_id_d", 32'(io_fthInst_id), 32'd2);
      cycle(0, 8'h00, 1, 0, 2'd0, 0, 0);
      chk("after_lock_id", 32'(io_fthInst_id), 32'd0);
      cycle(0, 8'h00, 1, 0, 2'd0, 0, 0);

      // Slot 1: continue, then finish and release.
      cycle(0, 8'h00, 0, 1, 2'd1, 0, 0);
      chk("nxt_fth_id", 32'(io_fthInst_id), 32'd1);
      cycle(0, 8'h00, 1, 0, 2'd0, 0, 0);
      cycle(0, 8'h00, 0, 1, 2'd1, 1, 0);
      chk("rel_valid", 32'(io_release_valid), 32'd1);
      chk("rel_id", 32'(io_release_id), 32'd1);
      chk("rel_not_alloc", 32'(io_alloc_ready), 32'd0);
      cycle(1, 8'h77, 0, 0, 2'd0, 0, 0);
      chk("rel_done", 32'(io_release_valid), 32'd0);
      chk("freed_alloc_id", 32'(io_alloc_id), 32'd1);
      cycle(0, 8'h00, 0, 1, 2'd1, 1, 0);
      chk("resp_free_ignored", 32'(io_release_valid), 32'd0);
      chk("resp_free_ready", 32'(io_alloc_ready), 32'd1);
      cycle(1, 8'h77, 0, 0, 2'd0, 0, 0);
      chk("realloc_tag", 32'(io_fthInst_tag), 32'h77);

      // Lock slot 1's request, then reset mid-flight.
      cycle(0, 8'h00, 0, 0, 2'd0, 0, 0);
      cycle(0, 8'h00, 0, 0, 2'd0, 0, 1);
      chk("mid_rst_alloc_ready", 32'(io_alloc_ready), 32'd1);
      chk("mid_rst_alloc_id", 32'(io_alloc_id), 32'd0);
      chk("mid_rst_fth_valid", 32'(io_fthInst_valid), 32'd0);
      chk("mid_rst_fth_id", 32'(io_fthInst_id), 32'd0);
      chk("mid_rst_release", 32'(io_release_valid), 32'd0);
      chk("mid_rst_busy", 32'(io_busy), 32'd0);
`ifdef TASK_SLOT_PERF_EN
      chk("mid_rst_perf_allocs", io_perf_allocs, 32'd0);
      chk("mid_rst_perf_fetches", io_perf_fetches, 32'd0);
      chk("mid_rst_perf_stalls", io_perf_stalls, 32'd0);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/task_slot_ctrl.md
# task_slot_ctrl

Controller for a pool of task slots. It allocates a free slot on each alloc handshake and drives each slot through a FREE → FSTTASK → WAIT → NXTTASK/DONE lifecycle. It round-robin arbitrates the instruction-fetch port among slots that need a fetch, and releases slots when their final response returns. It sits between the task dispatcher (alloc side) and the instruction fetch unit (fthInst side).

## Interface
- NUM_SLOTS, 4, number of task slots (power of two, 2..16)
- ID_W, 2, slot index width, equals log2(NUM_SLOTS)
- TAG_W, 8, task tag width carried from alloc to fetch

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- io_alloc_valid  in  1  dispatcher requests a slot
- io_alloc_tag  in  TAG_W  tag stored in the allocated slot
- io_alloc_ready  out  1  at least one slot is FREE
- io_alloc_id  out  ID_W  index of the slot granted this cycle
- io_fthInst_valid  out  1  fetch request pending
- io_fthInst_ready  in  1  fetch unit accepts
- io_fthInst_id  out  ID_W  requesting slot
- io_fthInst_tag  out  TAG_W  tag of requesting slot
- io_resp_valid  in  1  fetch response
- io_resp_id  in  ID_W  slot the response targets
- io_resp_last  in  1  final response of task
- io_release_valid  out  1  slot retiring this cycle
- io_release_id  out  ID_W  retiring slot
- io_busy  out  1  any slot not FREE

## Operation
- Per-slot state, 3 bits: FREE=0, FSTTASK=1, WAIT=2, NXTTASK=3, DONE=4.
- Alloc:
  - io_alloc_ready = any slot FREE.
  - io_alloc_id = lowest-index FREE slot (combinational).
  - On handshake (valid && ready), that slot → FSTTASK and latches io_alloc_tag.
- Fetch arbitration:
  - Requesters are slots in FSTTASK or NXTTASK.
  - Round-robin priority starts at ptr+1; ptr resets to NUM_SLOTS-1 so slot 0 wins first.
  - On fetch handshake, granted slot → WAIT and ptr ← granted id.
- Request lock: while io_fthInst_valid && !io_fthInst_ready, the chosen id is locked. id and tag stay stable until handshake, even if a higher-priority requester appears.
- Response:
  - io_resp_valid to a slot in WAIT: last=0 → NXTTASK; last=1 → DONE.
  - A response to a slot not in WAIT is ignored; no state change.
- Release:
  - A DONE slot drives io_release_valid for one cycle, then → FREE.
  - If several slots are in DONE, the lowest index is released first; the others stay DONE.
- Only valid slots are reported in io_release_id and io_fthInst_id; both read 0 when their valid is low.

## Timing
- Reset: all slots FREE, tags 0, ptr=NUM_SLOTS-1, lock clear.
- Output values during reset: io_alloc_ready=1, io_alloc_id=0, io_fthInst_valid=0, io_release_valid=0, io_busy=0.
- Alloc handshake at cycle t → slot FSTTASK at t+1 → io_fthInst_valid=1 at t+1 (Moore from state). Alloc-to-fetch latency is 1 cycle.
- Fetch handshake at t → WAIT at t+1.
- resp last=1 at t → DONE at t+1, io_release_valid at t+1 → FREE at t+2, allocatable at t+2.
- Release and alloc in the same cycle: the releasing slot is not allocatable that cycle.
- Pool full: io_alloc_ready=0; io_alloc_valid is held off with no state change.
- Reset asserted mid-operation: all state is discarded at the next edge, including a locked fetch request.
- A response and a fetch grant can never target the same slot in the same cycle (WAIT vs FSTTASK/NXTTASK).

## Configuration
- TASK_SLOT_PERF_EN defined: adds outputs io_perf_allocs, io_perf_fetches and io_perf_stalls, each 32 bits.
  - They count alloc handshakes, fetch handshakes, and cycles with io_fthInst_valid && !io_fthInst_ready.
  - All three clear on reset and saturate at max.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

## Structure
- task_slot_pkg holds:
  - slot_state_e enum with the encodings above
  - default NUM_SLOTS, ID_W, TAG_W constants
  - a slot record typedef {state, tag}
- Sub-module task_rr_arb: NUM_SLOTS request vector plus ptr in; one-hot grant and id out. Purely combinational.
- The lock register and ptr live in task_slot_ctrl.

## Test plan
- Reset, then alloc handshake with tag 0x5A → io_alloc_id=0, next cycle slot 0 FSTTASK, io_fthInst_valid=1, io_fthInst_tag=0x5A.
- Fill 4 slots back-to-back → io_alloc_ready=0 after the 4th handshake; a 5th io_alloc_valid is held until a release.
- Slots 0–3 all requesting with io_fthInst_ready=1 → grants 0, 1, 2, 3 in order, one per cycle.
- Hold io_fthInst_ready=0 for 3 cycles with slot 2 requesting, then slot 0 starts requesting → id stays 2 until handshake; slot 0 granted next.
- Slot 1 WAIT: resp last=0 → NXTTASK and re-request. resp last=1 → release_valid with id 1 one cycle later, FREE the cycle after. resp to a FREE slot → no change.
- Assert reset with 3 slots mid-flight and a locked request → all outputs at reset values next cycle. With TASK_SLOT_PERF_EN defined, the counters read 0.
